// File: rtl/highlight_pkg.sv
// rtl/highlight_pkg.sv - shared types and constants for the highlight write path
package highlight_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        OVERLAY = 2'd2,
        DONE    = 2'd3
    } sched_state_t;

    localparam int RGB_W = 24;
    localparam logic [RGB_W-1:0] HL_COLOR = 24'h0000FF;

endpackage

// File: rtl/hl_sync_fifo.sv
// rtl/hl_sync_fifo.sv - synchronous FIFO buffering early highlight writes
module hl_sync_fifo #(
    parameter int DATA_W = 44,
    parameter int DEPTH  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    // Extra pointer bit separates the full and empty cases when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/highlight_wr_scheduler.sv
// rtl/highlight_wr_scheduler.sv - orders loader and highlighter writes onto one BRAM port
module highlight_wr_scheduler
    import highlight_pkg::*;
#(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int IMAGE_SIZE = WIDTH * HEIGHT,
    parameter int ADDR_W     = $clog2(IMAGE_SIZE),
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [RGB_W-1:0]      ld_data,
    input  logic                  hl_wr_en,
    input  logic [ADDR_W-1:0]     hl_wr_addr,
    input  logic [RGB_W-1:0]      hl_wr_data,
    input  logic                  highlight_done,
    output logic                  bram_out_wr_en,
    output logic [ADDR_W-1:0]     bram_out_wr_addr,
    output logic [RGB_W-1:0]      bram_out_wr_data,
    output logic                  frame_ready,
    output logic                  busy,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int ENTRY_W = ADDR_W + RGB_W;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMAGE_SIZE - 1);

    sched_state_t          state_q, state_d;
    logic [ADDR_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic                  hl_done_seen_q, hl_done_seen_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [RGB_W-1:0]      wr_data_q, wr_data_d;
    logic                  busy_q;

    logic                  frame_go, ld_fire, hl_window, addr_ok, drop;
    logic                  fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]    fifo_dout;

    assign frame_go   = (state_q == IDLE) && frame_start;
    assign ld_ready   = (state_q == LOAD);
    assign ld_fire    = ld_valid && ld_ready;
    assign hl_window  = (state_q != IDLE);
    assign addr_ok    = 32'(hl_wr_addr) < IMAGE_SIZE;
    assign fifo_pop   = (state_q == OVERLAY) && !fifo_empty;
    // A push onto a full buffer still fits when the head leaves in the same cycle.
    assign fifo_push  = hl_wr_en && hl_window && addr_ok && (!fifo_full || fifo_pop);
    assign drop       = hl_wr_en && hl_window && !fifo_push;
    assign fifo_clear = reset || frame_go;

    hl_sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (fifo_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({hl_wr_addr, hl_wr_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        hl_done_seen_d = hl_done_seen_q;
        overflow_d     = overflow_q;
        drop_cnt_d     = drop_cnt_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = '0;
        wr_data_d      = '0;

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d        = LOAD;
                    pix_cnt_d      = '0;
                    hl_done_seen_d = 1'b0;
                    overflow_d     = 1'b0;
                    drop_cnt_d     = '0;
                end
            end
            LOAD: begin
                if (ld_fire) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_cnt_q;
                    wr_data_d = ld_data;
                    pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                    if (pix_cnt_q == LAST_PIX) state_d = OVERLAY;
                end
            end
            OVERLAY: begin
                if (fifo_pop) begin
                    wr_en_d                = 1'b1;
                    {wr_addr_d, wr_data_d} = fifo_dout;
                end
                if (hl_done_seen_q && fifo_empty && !fifo_push) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_q == LOAD || state_q == OVERLAY) && highlight_done) hl_done_seen_d = 1'b1;

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            pix_cnt_q      <= '0;
            hl_done_seen_q <= 1'b0;
            overflow_q     <= 1'b0;
            drop_cnt_q     <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            hl_done_seen_q <= hl_done_seen_d;
            overflow_q     <= overflow_d;
            drop_cnt_q     <= drop_cnt_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            busy_q         <= (state_d != IDLE);
        end
    end

    // Writes arriving in DONE are stranded until the next frame; the highlighter must not do this.
    always_ff @(posedge clock) begin
        if (!reset && state_q == DONE) begin
            assert (!hl_wr_en);
        end
    end

    assign bram_out_wr_en   = wr_en_q;
    assign bram_out_wr_addr = wr_addr_q;
    assign bram_out_wr_data = wr_data_q;
    assign frame_ready      = (state_q == DONE);
    assign busy             = busy_q;
    assign overflow         = overflow_q;
    assign drop_count       = drop_cnt_q;

endmodule

// File: tb/tb_highlight_wr_scheduler.sv
// tb/tb_highlight_wr_scheduler.sv - self-checking bench for highlight_wr_scheduler
module tb_highlight_wr_scheduler;
    import highlight_pkg::*;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int IMG   = W * H;
    localparam int AW    = $clog2(IMG);
    localparam int DEPTH = 4;
    localparam int DW    = 4;
    localparam int DSAT  = (1 << DW) - 1;

    typedef struct {
        int mode;
        int n_early;
        int at_pix;
        int addr_base;
        int n_late;
        int late_base;
        int done_delay;
        bit pre_done;
        bit fs_in_load;
        bit rnd;
        int exp_hl;
        int exp_drops;
        bit exp_ovf;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start = 1'b0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [RGB_W-1:0]  ld_data = '0;
    logic              hl_wr_en = 1'b0;
    logic [AW-1:0]     hl_wr_addr = '0;
    logic [RGB_W-1:0]  hl_wr_data = '0;
    logic              highlight_done = 1'b0;
    logic              bram_out_wr_en;
    logic [AW-1:0]     bram_out_wr_addr;
    logic [RGB_W-1:0]  bram_out_wr_data;
    logic              frame_ready;
    logic              busy;
    logic              overflow;
    logic [DW-1:0]     drop_count;

    int n_vec = 0;
    int n_err = 0;
    int fr_cnt = 0;
    logic [AW+RGB_W-1:0] got[$];

    highlight_wr_scheduler #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (DEPTH),
        .DROP_CNT_W (DW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .frame_start      (frame_start),
        .ld_valid         (ld_valid),
        .ld_ready         (ld_ready),
        .ld_data          (ld_data),
        .hl_wr_en         (hl_wr_en),
        .hl_wr_addr       (hl_wr_addr),
        .hl_wr_data       (hl_wr_data),
        .highlight_done   (highlight_done),
        .bram_out_wr_en   (bram_out_wr_en),
        .bram_out_wr_addr (bram_out_wr_addr),
        .bram_out_wr_data (bram_out_wr_data),
        .frame_ready      (frame_ready),
        .busy             (busy),
        .overflow         (overflow),
        .drop_count       (drop_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bram_out_wr_en) got.push_back({bram_out_wr_addr, bram_out_wr_data});
        if (frame_ready) fr_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic void pick(input bit rnd, input int idx, input int base,
                                 output logic [AW-1:0] a, output logic [RGB_W-1:0] d);
        if (rnd) begin
            a = AW'($urandom_range(0, IMG - 1));
            d = RGB_W'($urandom);
        end else begin
            a = AW'(base + idx);
            d = HL_COLOR;
        end
    endfunction

    // Reference: loader pixels land at 0..IMG-1 in order; pushes made during LOAD keep the
    // first DEPTH entries and drop the rest; pushes during OVERLAY always fit because the
    // buffer drains one entry every cycle there.
    task automatic run_frame(input vec_t r);
        logic [AW+RGB_W-1:0] exp_ld[$];
        logic [AW+RGB_W-1:0] exp_hl[$];
        logic [AW+RGB_W-1:0] e;
        logic [AW-1:0]       a;
        logic [RGB_W-1:0]    d;
        int n_pix = 0;
        int sent  = 0;
        int cyc   = 0;
        int drops = 0;
        int fr0;
        int n_cmp;
        bit seen  = 1'b0;

        got.delete();
        fr0 = fr_cnt;
        if (r.pre_done) begin
            highlight_done = 1'b1;
            step();
            highlight_done = 1'b0;
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;

        while (n_pix < IMG && cyc < 1000) begin
            case (r.mode)
                0:       ld_valid = 1'b1;
                1:       ld_valid = (cyc % 2 == 0);
                default: ld_valid = 1'($urandom_range(0, 1));
            endcase
            ld_data     = RGB_W'($urandom);
            hl_wr_en    = 1'b0;
            frame_start = r.fs_in_load && (cyc == 5);
            if (n_pix >= r.at_pix && sent < r.n_early) begin
                pick(r.rnd, sent, r.addr_base, a, d);
                hl_wr_en   = 1'b1;
                hl_wr_addr = a;
                hl_wr_data = d;
                if (int'(a) < IMG && exp_hl.size() < DEPTH) exp_hl.push_back({a, d});
                else drops++;
                sent++;
            end
            chk("ld_ready_in_load", ld_ready, 1);
            if (ld_valid) begin
                exp_ld.push_back({AW'(n_pix), ld_data});
                n_pix++;
            end
            step();
            cyc++;
        end
        ld_valid    = 1'b0;
        hl_wr_en    = 1'b0;
        frame_start = 1'b0;
        chk("load_within_budget", n_pix, IMG);
        chk("ld_ready_after_load", ld_ready, 0);

        for (int i = 0; i < r.n_late; i++) begin
            pick(r.rnd, i, r.late_base, a, d);
            hl_wr_en   = 1'b1;
            hl_wr_addr = a;
            hl_wr_data = d;
            if (int'(a) < IMG) exp_hl.push_back({a, d});
            else drops++;
            step();
        end
        hl_wr_en = 1'b0;

        repeat (r.done_delay) step();
        if (r.done_delay > 0) begin
            chk("no_frame_ready_before_done", fr_cnt - fr0, 0);
            chk("busy_awaiting_done", busy, 1);
        end

        highlight_done = 1'b1;
        step();
        highlight_done = 1'b0;

        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clock);
            seen = frame_ready;
        end
        chk("frame_ready_seen", seen, 1);
        chk("busy_in_done", busy, 1);
        @(negedge clock);
        chk("frame_ready_single_cycle", frame_ready, 0);
        chk("busy_after_done", busy, 0);
        step();

        chk("frame_ready_count", fr_cnt - fr0, 1);
        chk("write_count", got.size(), exp_ld.size() + exp_hl.size());
        n_cmp = (got.size() < exp_ld.size() + exp_hl.size()) ? got.size()
                                                             : exp_ld.size() + exp_hl.size();
        for (int i = 0; i < n_cmp; i++) begin
            e = (i < exp_ld.size()) ? exp_ld[i] : exp_hl[i - exp_ld.size()];
            chk($sformatf("write_seq[%0d]", i), got[i], e);
        end
        chk("drop_count_model", drop_count, (drops > DSAT) ? DSAT : drops);
        chk("overflow_model", overflow, (drops > 0));
    endtask

    initial begin
        vec_t vecs[7];
        vec_t rv;

        //           mode early at  base late lbase delay pre fs  rnd  hl drops ovf
        vecs[0] = '{0,   0,    0,  0,   3,   5,    0,    0,  0,  0,   3, 0,    0};
        vecs[1] = '{0,   2,    12, 10,  0,   0,    0,    0,  0,  0,   2, 0,    0};
        vecs[2] = '{0,   6,    3,  0,   0,   0,    0,    0,  0,  0,   4, 2,    1};
        vecs[3] = '{1,   0,    0,  0,   0,   0,    0,    0,  0,  0,   0, 0,    0};
        vecs[4] = '{0,   0,    0,  0,   1,   9,    10,   1,  1,  0,   1, 0,    0};
        vecs[5] = '{0,   24,   2,  0,   0,   0,    0,    0,  0,  0,   4, DSAT, 1};
        vecs[6] = '{1,   3,    20, 1,   4,   20,   2,    0,  0,  0,   7, 0,    0};

        repeat (3) step();
        @(negedge clock);
        chk("reset_ld_ready", ld_ready, 0);
        chk("reset_wr_en", bram_out_wr_en, 0);
        chk("reset_wr_addr", bram_out_wr_addr, 0);
        chk("reset_wr_data", bram_out_wr_data, 0);
        chk("reset_frame_ready", frame_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_drop_count", drop_count, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i]);
            chk($sformatf("tbl%0d_hl_writes", i), got.size() - IMG, vecs[i].exp_hl);
            chk($sformatf("tbl%0d_drop_count", i), drop_count, vecs[i].exp_drops);
            chk($sformatf("tbl%0d_overflow", i), overflow, vecs[i].exp_ovf);
        end

        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ld_valid   = 1'b1;
            ld_data    = RGB_W'(i);
            hl_wr_en   = (i < 6);
            hl_wr_addr = AW'(i);
            hl_wr_data = HL_COLOR;
            step();
        end
        hl_wr_en = 1'b0;
        chk("midreset_pre_overflow", overflow, 1);
        chk("midreset_pre_drops", drop_count, 2);
        reset = 1'b1;
        step();
        @(negedge clock);
        chk("midreset_wr_en", bram_out_wr_en, 0);
        chk("midreset_wr_addr", bram_out_wr_addr, 0);
        chk("midreset_wr_data", bram_out_wr_data, 0);
        chk("midreset_ld_ready", ld_ready, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_frame_ready", frame_ready, 0);
        chk("midreset_overflow", overflow, 0);
        chk("midreset_drop_count", drop_count, 0);
        reset    = 1'b0;
        ld_valid = 1'b0;
        step();
        run_frame(vecs[0]);
        chk("after_reset_hl_writes", got.size() - IMG, 3);

        for (int f = 0; f < 8; f++) begin
            rv.mode       = int'($urandom_range(0, 2));
            rv.n_early    = int'($urandom_range(0, 8));
            rv.at_pix     = int'($urandom_range(0, 20));
            rv.addr_base  = 0;
            rv.n_late     = int'($urandom_range(0, 6));
            rv.late_base  = 0;
            rv.done_delay = int'($urandom_range(0, 3));
            rv.pre_done   = 1'($urandom_range(0, 1));
            rv.fs_in_load = 1'($urandom_range(0, 1));
            rv.rnd        = 1'b1;
            rv.exp_hl     = 0;
            rv.exp_drops  = 0;
            rv.exp_ovf    = 1'b0;
            run_frame(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
